// File: rtl/bus_trace_tx.sv
// Bus trace transmitter: snoops bus-driver cycles into 16-bit records, buffers them
// in a small FIFO and ships each one as a UART-style frame (start, 16 bits LSB first, stop).
//
// state   | meaning
// S_IDLE  | line high; pops the FIFO head into the shift register when non-empty
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | 16 record bits, LSB first, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (high) for CLKS_PER_BIT cycles
module bus_trace_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ctrl,
    input  logic [7:0]  bus,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL   = DEPTH[AW:0];
    localparam logic [15:0] CPB_M1 = 16'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state;
    logic [15:0]   clk_cnt;
    logic [3:0]    bit_cnt;
    logic [15:0]   shreg;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          drop_pend;

    logic          capture;
    logic          multi_drv;
    logic [1:0]    src;
    logic [15:0]   record;
    logic          pop;
    logic          push;
    logic          drop;

    // ALU mode bits are not part of the record.
    logic          unused_alu_mode;
    assign unused_alu_mode = ^ctrl[10:7];

    assign capture   = ctrl[6] | ctrl[2] | ctrl[0];
    assign multi_drv = (ctrl[6] & ctrl[2]) | (ctrl[6] & ctrl[0]) | (ctrl[2] & ctrl[0]);

    always_comb begin
        src = 2'b00;
        if (!multi_drv) begin
            if (ctrl[6])
                src = 2'b01;
            else if (ctrl[2])
                src = 2'b10;
            else if (ctrl[0])
                src = 2'b11;
        end
    end

    assign record = {src, ctrl[5], ctrl[4], ctrl[3], ctrl[1], drop_pend, 1'b0, bus};

    assign pop  = (state == S_IDLE) && (count != '0);
    assign push = capture && ((count != FULL) || pop);
    assign drop = capture && !push;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= record;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            drop_pend <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                drop_pend <= 1'b0;
            end
            if (drop) begin
                drop_pend <= 1'b1;
                overflow  <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        clk_cnt <= CPB_M1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt == '0) begin
                        clk_cnt <= CPB_M1;
                        bit_cnt <= 4'd15;
                        state   <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == '0) begin
                        clk_cnt <= CPB_M1;
                        shreg   <= {1'b0, shreg[15:1]};
                        if (bit_cnt == '0)
                            state <= S_STOP;
                        else
                            bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt - 1'b1;
                    end
                end
                default: begin
                    if (clk_cnt == '0)
                        state <= S_IDLE;
                    else
                        clk_cnt <= clk_cnt - 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = shreg[0];
            default: tx = 1'b1;
        endcase
    end

    assign busy = (state != S_IDLE) || (count != '0);

endmodule

// File: tb/tb_bus_trace_tx.sv
// Bench for bus_trace_tx: stimulus queues expected records, a serial monitor decodes
// frames from tx and pops/compares them; directed timing checks run inline.
`timescale 1ns/1ps
module tb_bus_trace_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] ctrl = '0;
    logic [7:0]  bus = '0;
    logic        tx;
    logic        busy;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    bus_trace_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .ctrl(ctrl),
        .bus(bus),
        .tx(tx),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [10:0] c, input logic [7:0] b);
        ctrl = c;
        bus  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ctrl = '0;
        bus  = '0;
    endtask

    task automatic idle(input int n);
        quiet();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        quiet();
        while (busy === 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 0);
        @(posedge clk);
        #1;
    endtask

    // Serial monitor: start-edge detect, sample mid-bit, compare against scoreboard.
    logic        mon_active = 1'b0;
    int          mon_cnt = 0;
    logic [15:0] mon_sh = '0;
    logic        prev_tx = 1'b1;
    int          idle_run = 0;
    logic        gap_valid = 1'b0;
    logic        gap_busy = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
            gap_valid  = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0 && prev_tx === 1'b1) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                if (gap_valid && gap_busy)
                    chk("frame_gap", idle_run, 1);
                gap_valid = 1'b0;
            end else begin
                idle_run++;
                gap_busy = gap_busy & busy;
                if (gap_valid && idle_run == 1 && exp_q.size() == 0)
                    chk("busy_after_stop", busy, 0);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 2)
                chk("start_bit", tx, 0);
            if (mon_cnt >= 6 && mon_cnt <= 66 && (mon_cnt - 6) % 4 == 0)
                mon_sh = {tx, mon_sh[15:1]};
            if (mon_cnt == 70) begin
                chk("stop_bit", tx, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %04h, expected none", mon_sh);
                end else begin
                    chk("record", mon_sh, exp_q.pop_front());
                end
            end
            if (mon_cnt == 71) begin
                mon_active = 1'b0;
                idle_run   = 0;
                gap_busy   = 1'b1;
                gap_valid  = 1'b1;
            end
        end
        prev_tx = tx;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        logic low_seen;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        // single transfer: R3 drives, R1 writes
        exp_q.push_back(16'hA055);
        cyc(11'b000_0010_0100, 8'h55);
        quiet();
        @(negedge clk);
        chk("lat1_tx", tx, 1);
        chk("lat1_busy", busy, 1);
        @(negedge clk);
        chk("lat2_tx_fall", tx, 0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("frame_len", n, 72);
        @(posedge clk);
        #1;

        // contention, all-writes R4, ALU with mode bits set
        exp_q.push_back(16'h102A);
        cyc(11'h051, 8'h2A);
        exp_q.push_back(16'hFCC3);
        cyc(11'h03B, 8'hC3);
        exp_q.push_back(16'h4081);
        cyc(11'h540, 8'h81);
        wait_idle("idle_after_mix", 400);

        // overflow: 7 consecutive captures from idle
        for (int i = 1; i <= 7; i++) begin
            if (i <= 5)
                exp_q.push_back({8'hC0, 8'(i)});
            cyc(11'h001, 8'(i));
            if (i == 5)
                chk("ovf_before_drop", overflow, 0);
        end
        quiet();
        chk("ovf_set", overflow, 1);
        wait_idle("idle_after_ovf", 600);
        chk("ovf_sticky", overflow, 1);
        exp_q.push_back(16'hC2AA);
        cyc(11'h001, 8'hAA);
        exp_q.push_back(16'hC0BB);
        cyc(11'h001, 8'hBB);
        wait_idle("idle_after_dropflag", 400);
        chk("ovf_still_set", overflow, 1);

        // reset mid-frame with a record still buffered
        cyc(11'h004, 8'h77);
        cyc(11'h004, 8'h78);
        idle(20);
        reset = 1'b1;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_overflow", overflow, 0);
        idle(2);
        reset = 1'b0;
        low_seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (tx !== 1'b1)
                low_seen = 1'b1;
        end
        chk("no_frame_after_rst", low_seen, 0);
        chk("busy_after_rst", busy, 0);
        @(posedge clk);
        #1;

        // full FIFO + pop + capture on the same edge
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({8'h60, 8'(8'h11 + i)});
            cyc(11'h060, 8'(8'h11 + i));
        end
        idle(69);
        @(negedge clk);
        chk("fullpop_idle_tx", tx, 1);
        chk("fullpop_busy", busy, 1);
        exp_q.push_back(16'h6016);
        cyc(11'h060, 8'h16);
        quiet();
        chk("fullpop_no_drop", overflow, 0);
        cyc(11'h060, 8'h17);
        quiet();
        chk("full_drop", overflow, 1);
        wait_idle("idle_after_full", 800);
        exp_q.push_back(16'h6299);
        cyc(11'h060, 8'h99);
        wait_idle("idle_final", 400);

        idle(4);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
